// File: rtl/hs_clk_ctrl.sv
// MIPI D-PHY HS clock-lane sequencer: zero -> prepare -> active -> post -> trail, timed by an external down-counter.
// Optional HS_CLK_CTRL_ABORT_EN: hs_enable low during start-up returns straight to IDLE_OFF.
module hs_clk_ctrl #(
  parameter int ZERO_CLK  = 27,
  parameter int RX_SETUP  = 4,
  parameter int POST_DATA = 6,
  parameter int STOP_CLK  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs_enable,
  input  logic       hs_req,
  input  logic       time_pass,
  output logic       hs_clk,
  output logic       hs_active,
  output logic       timer_enable,
  output logic [5:0] timer_reload
);

`ifdef HS_CLK_CTRL_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE_OFF    = 3'd0,
    HS_START    = 3'd1,
    CLK_PREPARE = 3'd2,
    HS_ACTIVE   = 3'd3,
    PRE_HS_STOP = 3'd4,
    HS_STOP     = 3'd5
  } state_t;

  state_t     current_state;
  state_t     next_state;
  logic       timed_nxt;
  logic [5:0] reload_nxt;
  logic       expired;

  // timer_enable is low during the load cycle, so expiry is only honoured once counting
  assign expired = time_pass && timer_enable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) current_state <= IDLE_OFF;
    else      current_state <= next_state;
  end

  always_comb begin
    next_state = current_state;
    case (current_state)
      IDLE_OFF:    if (hs_enable && hs_req) next_state = HS_START;
      HS_START: begin
        if (expired) next_state = CLK_PREPARE;
        if (ABORT_EN && !hs_enable) next_state = IDLE_OFF;
      end
      CLK_PREPARE: begin
        if (expired) next_state = HS_ACTIVE;
        if (ABORT_EN && !hs_enable) next_state = IDLE_OFF;
      end
      HS_ACTIVE:   if (!hs_req || !hs_enable) next_state = PRE_HS_STOP;
      PRE_HS_STOP: if (expired) next_state = HS_STOP;
      HS_STOP:     if (expired) next_state = IDLE_OFF;
      default:     next_state = IDLE_OFF;
    endcase
  end

  always_comb begin
    timed_nxt  = 1'b1;
    reload_nxt = 6'd0;
    case (next_state)
      HS_START:    reload_nxt = 6'(ZERO_CLK);
      CLK_PREPARE: reload_nxt = 6'(RX_SETUP);
      PRE_HS_STOP: reload_nxt = 6'(POST_DATA);
      HS_STOP:     reload_nxt = 6'(STOP_CLK);
      default:     timed_nxt  = 1'b0;
    endcase
  end

  // Outputs decoded from next_state so they move on the same edge as current_state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_clk       <= 1'b0;
      hs_active    <= 1'b0;
      timer_enable <= 1'b0;
      timer_reload <= 6'd0;
    end else begin
      hs_clk       <= (next_state == CLK_PREPARE) || (next_state == HS_ACTIVE) ||
                      (next_state == PRE_HS_STOP);
      hs_active    <= (next_state == HS_ACTIVE);
      timer_enable <= timed_nxt && (next_state == current_state);
      timer_reload <= reload_nxt;
    end
  end

endmodule

// File: tb/tb_hs_clk_ctrl.sv
// Directed bench for hs_clk_ctrl: reset, start-up, shutdown, spurious expiry, early request drop, abort and async reset.
module tb_hs_clk_ctrl;

  localparam int S_IDLE = 0, S_START = 1, S_PREP = 2, S_ACT = 3, S_POST = 4, S_STOP = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       hs_enable;
  logic       hs_req;
  logic       time_pass;
  logic       hs_clk;
  logic       hs_active;
  logic       timer_enable;
  logic [5:0] timer_reload;

  int n_checks = 0;
  int n_fail   = 0;

  hs_clk_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .hs_enable    (hs_enable),
    .hs_req       (hs_req),
    .time_pass    (time_pass),
    .hs_clk       (hs_clk),
    .hs_active    (hs_active),
    .timer_enable (timer_enable),
    .timer_reload (timer_reload)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // state, hs_clk, hs_active, timer_enable, timer_reload in one go
  task automatic expect_all(input string tag, input int st, input int hc, input int ha,
                            input int te, input int rl);
    check({tag, ".state"},  int'(dut.current_state), st);
    check({tag, ".hs_clk"}, int'(hs_clk), hc);
    check({tag, ".hs_act"}, int'(hs_active), ha);
    check({tag, ".t_en"},   int'(timer_enable), te);
    check({tag, ".reload"}, int'(timer_reload), rl);
  endtask

  task automatic pulse_tp();
    time_pass = 1'b1;
    tick();
    time_pass = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; hs_enable = 1'b0; hs_req = 1'b0; time_pass = 1'b0;
    repeat (10) tick();
    expect_all("in_reset", S_IDLE, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    expect_all("post_reset", S_IDLE, 0, 0, 0, 0);

    // spurious expiry while idle
    pulse_tp();
    expect_all("tp_idle", S_IDLE, 0, 0, 0, 0);

    // start-up
    hs_enable = 1'b1; hs_req = 1'b1;
    tick();
    expect_all("start_load", S_START, 0, 0, 0, 27);
    pulse_tp();                       // lands on the load cycle: ignored
    expect_all("start_cnt", S_START, 0, 0, 1, 27);
    repeat (3) tick();
    expect_all("start_hold", S_START, 0, 0, 1, 27);
    pulse_tp();
    expect_all("prep_load", S_PREP, 1, 0, 0, 4);
    tick();
    expect_all("prep_cnt", S_PREP, 1, 0, 1, 4);
    pulse_tp();
    expect_all("active", S_ACT, 1, 1, 0, 0);
    pulse_tp();
    expect_all("tp_active", S_ACT, 1, 1, 0, 0);
    repeat (20) tick();
    check("active_hold", int'(dut.current_state), S_ACT);

    // shutdown; late request must not interrupt it
    hs_req = 1'b0;
    tick();
    expect_all("post_load", S_POST, 1, 0, 0, 6);
    hs_req = 1'b1;
    tick();
    expect_all("post_cnt", S_POST, 1, 0, 1, 6);
    pulse_tp();
    expect_all("stop_load", S_STOP, 0, 0, 0, 6);
    tick();
    expect_all("stop_cnt", S_STOP, 0, 0, 1, 6);
    pulse_tp();
    expect_all("back_idle", S_IDLE, 0, 0, 0, 0);
    hs_req = 1'b0;
    tick();
    check("idle_stays", int'(dut.current_state), S_IDLE);

    // request dropped during HS_START: start-up completes, one HS_ACTIVE cycle
    hs_req = 1'b1;
    tick();
    check("drop_start", int'(dut.current_state), S_START);
    hs_req = 1'b0;
    tick();
    pulse_tp();
    check("drop_prep", int'(dut.current_state), S_PREP);
    tick();
    pulse_tp();
    expect_all("drop_act", S_ACT, 1, 1, 0, 0);
    tick();
    expect_all("drop_post", S_POST, 1, 0, 0, 6);
    tick(); pulse_tp(); tick(); pulse_tp();
    check("drop_idle", int'(dut.current_state), S_IDLE);

    // hs_enable low together with expiry in CLK_PREPARE
    hs_enable = 1'b1; hs_req = 1'b1;
    tick(); tick(); pulse_tp(); tick();
    expect_all("abort_prep", S_PREP, 1, 0, 1, 4);
    hs_enable = 1'b0; hs_req = 1'b0;
`ifdef HS_CLK_CTRL_ABORT_EN
    pulse_tp();
    expect_all("abort_idle", S_IDLE, 0, 0, 0, 0);
`else
    pulse_tp();
    expect_all("noabort_act", S_ACT, 1, 1, 0, 0);
    tick();
    expect_all("noabort_post", S_POST, 1, 0, 0, 6);
    tick(); pulse_tp(); tick(); pulse_tp();
    check("noabort_idle", int'(dut.current_state), S_IDLE);
`endif

    // asynchronous reset from HS_ACTIVE, between clock edges
    hs_enable = 1'b1; hs_req = 1'b1;
    tick(); tick(); pulse_tp(); tick(); pulse_tp();
    check("pre_arst", int'(dut.current_state), S_ACT);
    #2;
    rst = 1'b0;
    #1;
    expect_all("arst", S_IDLE, 0, 0, 0, 0);
    hs_enable = 1'b0; hs_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("arst_idle", int'(dut.current_state), S_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hs_clk_ctrl.md
# hs_clk_ctrl

HS clock-lane sequencer for the MIPI D-PHY transmitter. It walks the clock lane through its start-up phases (zero, prepare/pre), HS-active, and shutdown phases (post, trail). An external down-counter measures each phase's duration: this block loads that counter and advances when it reports expiry. It sits between the lane-control logic (`hs_enable`/`hs_req`) and the clock-lane serializer/driver (`hs_clk`/`hs_active`).

## Interface
- `ZERO_CLK`, default 27: timer count for the HS_START (clock-zero) phase.
- `RX_SETUP`, default 4: timer count for the CLK_PREPARE (receiver setup / clock-pre) phase.
- `POST_DATA`, default 6: timer count for the PRE_HS_STOP (clock-post) phase.
- `STOP_CLK`, default 6: timer count for the HS_STOP (trail) phase.
- All four parameters must lie in the range 1..63.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `hs_enable`  in  1  HS mode permitted by lane control.
- `hs_req`  in  1  HS transmission request; a level, held high for the whole burst.
- `time_pass`  in  1  one-cycle pulse from the external timer; the loaded count has expired.
- `hs_clk`  out  1  HS clock-run enable to the serializer.
- `hs_active`  out  1  clock lane in HS-active phase.
- `timer_enable`  out  1  external timer control: low = load `timer_reload`, high = count down.
- `timer_reload`  out  6  count for the current timed phase.

## Operation
- The state register is named `current_state`, with states `IDLE_OFF`, `HS_START`, `CLK_PREPARE`, `HS_ACTIVE`, `PRE_HS_STOP`, `HS_STOP`. These names are visible hierarchically for verification.
- Transitions:
  - `IDLE_OFF` -> `HS_START` when `hs_enable && hs_req`.
  - `HS_START` -> `CLK_PREPARE` on `time_pass`.
  - `CLK_PREPARE` -> `HS_ACTIVE` on `time_pass`.
  - `HS_ACTIVE` -> `PRE_HS_STOP` when `!hs_req || !hs_enable`.
  - `PRE_HS_STOP` -> `HS_STOP` on `time_pass`.
  - `HS_STOP` -> `IDLE_OFF` on `time_pass`.
- Timed states and their `timer_reload` values:
  - `HS_START` uses `ZERO_CLK`.
  - `CLK_PREPARE` uses `RX_SETUP`.
  - `PRE_HS_STOP` uses `POST_DATA`.
  - `HS_STOP` uses `STOP_CLK`.
  - In untimed states, `timer_reload` = 0.
- `timer_enable` is low in untimed states. It is also low for exactly the first cycle of every timed state (the load cycle), and high for the rest of that state.
- `time_pass` is ignored in untimed states and during the load cycle.
- `hs_clk` = 1 in `CLK_PREPARE`, `HS_ACTIVE` and `PRE_HS_STOP`; 0 otherwise.
- `hs_active` = 1 only in `HS_ACTIVE`.
- If `hs_req` drops during `HS_START` or `CLK_PREPARE`, the start-up sequence completes. The block then enters `HS_ACTIVE` for one cycle and leaves on the next edge.
- Once in `PRE_HS_STOP` or `HS_STOP`, shutdown always completes. `hs_req` and `hs_enable` are ignored until `IDLE_OFF` is reached.

## Timing
- Reset (`rst` = 0), asynchronous: `current_state` = `IDLE_OFF`, `hs_clk` = 0, `hs_active` = 0, `timer_enable` = 0, `timer_reload` = 0. This applies mid-operation as well.
- All outputs are registered and decoded from the next state, so they change on the same edge as `current_state`.
- Request to start-up: 1 cycle from `hs_enable && hs_req` sampled high to `current_state` = `HS_START`.
- Each timed state lasts (load cycle + counter duration + 1) cycles. It leaves on the edge where `time_pass` = 1.
- Exit from `HS_ACTIVE`: 1 cycle after `hs_req` is sampled low. `hs_clk` keeps running through `PRE_HS_STOP`.
- Simultaneous `time_pass` and `hs_enable` low in `HS_START`/`CLK_PREPARE`: the abort has priority (see Configuration).

## Configuration
- `HS_CLK_CTRL_ABORT_EN` defined: `hs_enable` sampled low in `HS_START` or `CLK_PREPARE` returns the block to `IDLE_OFF` on the next edge, with all outputs at their reset values.
- `HS_CLK_CTRL_ABORT_EN` undefined: `hs_enable` is sampled only in `IDLE_OFF` and `HS_ACTIVE`, and the start-up sequence always completes.

## Test plan
- Reset: hold `rst` = 0 for 10 cycles, release with `hs_enable` = `hs_req` = 0 -> `hs_clk` = `hs_active` = `timer_enable` = 0, `current_state` = `IDLE_OFF`.
- Start-up: `hs_enable` = `hs_req` = 1 -> `HS_START`, then after the load cycle `timer_enable` = 1 with `timer_reload` = 27. Pulse `time_pass` -> `CLK_PREPARE` (`timer_reload` = 4, `hs_clk` = 1). Pulse `time_pass` -> `HS_ACTIVE` with `hs_active` = `hs_clk` = 1.
- Shutdown: after 20 cycles in `HS_ACTIVE`, drop `hs_req` -> `PRE_HS_STOP` (`timer_reload` = 6, `hs_active` = 0, `hs_clk` = 1). Pulse `time_pass` -> `HS_STOP` (`hs_clk` = 0). Pulse `time_pass` -> `IDLE_OFF`.
- Spurious `time_pass` in `IDLE_OFF`, in `HS_ACTIVE`, or during a load cycle -> no state change.
- `hs_enable` = 0 during `CLK_PREPARE`, with the macro defined -> `IDLE_OFF` on the next edge. Without the macro -> `HS_ACTIVE` on `time_pass`, then `PRE_HS_STOP` one cycle later.
- Assert `rst` = 0 while in `HS_ACTIVE` -> all outputs 0 immediately, without waiting for a clock edge.
